// File: rtl/switch_arbiter_if.sv
// rtl/switch_arbiter_if.sv - request/grant/crossbar-select bundle between switch ports and the arbiter
interface switch_arbiter_if;
  logic [3:0] req;
  logic [3:0] pkt_dst0;
  logic [3:0] pkt_dst1;
  logic [3:0] pkt_dst2;
  logic [3:0] pkt_dst3;
  logic [3:0] grant;
  logic [3:0] arb_active;
  logic [1:0] mux_select0;
  logic [1:0] mux_select1;
  logic [1:0] mux_select2;
  logic [1:0] mux_select3;
  logic [1:0] rr_ptr;

  modport master (
    output req, pkt_dst0, pkt_dst1, pkt_dst2, pkt_dst3,
    input  grant, arb_active, mux_select0, mux_select1, mux_select2, mux_select3, rr_ptr
  );

  modport slave (
    input  req, pkt_dst0, pkt_dst1, pkt_dst2, pkt_dst3,
    output grant, arb_active, mux_select0, mux_select1, mux_select2, mux_select3, rr_ptr
  );
endinterface

// File: rtl/switch_arbiter.sv
// rtl/switch_arbiter.sv - 4-port round-robin output arbiter with all-or-nothing multicast grants
module switch_arbiter (
  input  logic             clk,
  input  logic             rst_n,
  switch_arbiter_if.slave  arb
);

  logic [3:0] dst_m [4];
  logic [3:0] grant_q, grant_n;
  logic [3:0] active_q, active_n;
  logic [1:0] sel_q [4];
  logic [1:0] sel_n [4];
  logic [1:0] rr_q, rr_n;
  logic [3:0] claimed;
  logic [1:0] idx;
  logic [1:0] first_idx;
  logic       first_hit;

  // Masks of idle sources are forced to zero so X on an unused header never leaks.
  assign dst_m[0] = {4{arb.req[0]}} & arb.pkt_dst0;
  assign dst_m[1] = {4{arb.req[1]}} & arb.pkt_dst1;
  assign dst_m[2] = {4{arb.req[2]}} & arb.pkt_dst2;
  assign dst_m[3] = {4{arb.req[3]}} & arb.pkt_dst3;

  always_comb begin
    claimed   = 4'b0000;
    grant_n   = 4'b0000;
    first_hit = 1'b0;
    first_idx = rr_q;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      // A source granted last cycle still shows req while it moves to TRANSMIT.
      if ((dst_m[idx] != 4'b0000) && !grant_q[idx] && ((dst_m[idx] & claimed) == 4'b0000)) begin
        grant_n[idx] = 1'b1;
        claimed      = claimed | dst_m[idx];
        if (!first_hit) begin
          first_hit = 1'b1;
          first_idx = idx;
        end
      end
    end
    rr_n     = first_hit ? (first_idx + 2'd1) : rr_q;
    active_n = claimed;
    for (int j = 0; j < 4; j++) begin
      sel_n[j] = sel_q[j];
      for (int i = 0; i < 4; i++) begin
        if (grant_n[i] && dst_m[i][j]) begin
          sel_n[j] = 2'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= 4'b0000;
      active_q <= 4'b0000;
      rr_q     <= 2'd0;
      for (int j = 0; j < 4; j++) begin
        sel_q[j] <= 2'd0;
      end
    end else begin
      grant_q  <= grant_n;
      active_q <= active_n;
      rr_q     <= rr_n;
      for (int j = 0; j < 4; j++) begin
        sel_q[j] <= sel_n[j];
      end
    end
  end

  assign arb.grant       = grant_q;
  assign arb.arb_active  = active_q;
  assign arb.mux_select0 = sel_q[0];
  assign arb.mux_select1 = sel_q[1];
  assign arb.mux_select2 = sel_q[2];
  assign arb.mux_select3 = sel_q[3];
  assign arb.rr_ptr      = rr_q;

endmodule

// File: tb/tb_switch_arbiter.sv
// tb/tb_switch_arbiter.sv - scoreboard bench for switch_arbiter with hand-computed directed vectors
module tb_switch_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  switch_arbiter_if bus ();

  switch_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] v;
  } exp_t;

  exp_t exp_q [$];

  function automatic logic [17:0] observed();
    return {bus.grant, bus.arb_active, bus.mux_select0, bus.mux_select1,
            bus.mux_select2, bus.mux_select3, bus.rr_ptr};
  endfunction

  task automatic compare(input string nm, input logic [17:0] act, input logic [17:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got g=%b a=%b s0..3=%0d%0d%0d%0d rr=%0d, want g=%b a=%b s0..3=%0d%0d%0d%0d rr=%0d",
               nm, act[17:14], act[13:10], act[9:8], act[7:6], act[5:4], act[3:2], act[1:0],
               req_v[17:14], req_v[13:10], req_v[9:8], req_v[7:6], req_v[5:4], req_v[3:2], req_v[1:0]);
    end
  endtask

  // Expected tuple is the register state after the edge that samples these inputs.
  task automatic step(input string nm, input logic [3:0] r,
                      input logic [3:0] d0, input logic [3:0] d1,
                      input logic [3:0] d2, input logic [3:0] d3,
                      input logic [3:0] g, input logic [3:0] a,
                      input logic [1:0] s0, input logic [1:0] s1,
                      input logic [1:0] s2, input logic [1:0] s3,
                      input logic [1:0] rr);
    exp_t e;
    @(negedge clk);
    bus.req      = r;
    bus.pkt_dst0 = d0;
    bus.pkt_dst1 = d1;
    bus.pkt_dst2 = d2;
    bus.pkt_dst3 = d3;
    e.name = nm;
    e.v    = {g, a, s0, s1, s2, s3, rr};
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare(e.name, observed(), e.v);
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    bus.req = 4'b0000;
    bus.pkt_dst0 = 4'b0000;
    bus.pkt_dst1 = 4'b0000;
    bus.pkt_dst2 = 4'b0000;
    bus.pkt_dst3 = 4'b0000;
    rst_n = 1'b0;
    #1;
    compare("reset_state", observed(), 18'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step("idle0", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    step("idle1", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

    step("uni_c1", 4'b0001, 4'b0100, 4'h0, 4'h0, 4'h0, 4'b0001, 4'b0100, 0, 0, 0, 0, 1);
    step("uni_c2", 4'b0001, 4'b0100, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
    step("uni_c3", 4'b0001, 4'b0100, 4'h0, 4'h0, 4'h0, 4'b0001, 4'b0100, 0, 0, 0, 0, 1);
    step("uni_idle", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);

    step("rr_to0", 4'b1000, 4'h0, 4'h0, 4'h0, 4'b0001, 4'b1000, 4'b0001, 3, 0, 0, 0, 0);
    step("conf_c1", 4'b0011, 4'b0100, 4'b0100, 4'h0, 4'bxxxx, 4'b0001, 4'b0100, 3, 0, 0, 0, 1);
    step("conf_c2", 4'b0011, 4'b0100, 4'b0100, 4'h0, 4'bxxxx, 4'b0010, 4'b0100, 3, 0, 1, 0, 2);
    step("conf_c3", 4'b0011, 4'b0100, 4'b0100, 4'h0, 4'bxxxx, 4'b0001, 4'b0100, 3, 0, 0, 0, 1);
    step("conf_c4", 4'b0011, 4'b0100, 4'b0100, 4'h0, 4'bxxxx, 4'b0010, 4'b0100, 3, 0, 1, 0, 2);
    step("conf_idle", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 3, 0, 1, 0, 2);

    step("rr_to0b", 4'b1000, 4'h0, 4'h0, 4'h0, 4'b0001, 4'b1000, 4'b0001, 3, 0, 1, 0, 0);
    step("parallel", 4'b0101, 4'b0010, 4'h0, 4'b1000, 4'h0, 4'b0101, 4'b1010, 3, 0, 1, 2, 1);
    step("par_idle", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 3, 0, 1, 2, 1);

    step("rr_to2", 4'b0010, 4'h0, 4'b0001, 4'h0, 4'h0, 4'b0010, 4'b0001, 1, 0, 1, 2, 2);
    step("bcast_c1", 4'b0110, 4'h0, 4'b1111, 4'b0001, 4'h0, 4'b0100, 4'b0001, 2, 0, 1, 2, 3);
    step("bcast_c2", 4'b0110, 4'h0, 4'b1111, 4'b0001, 4'h0, 4'b0010, 4'b1111, 1, 1, 1, 1, 2);
    step("bcast_c3", 4'b0110, 4'h0, 4'b1111, 4'b0001, 4'h0, 4'b0100, 4'b0001, 2, 1, 1, 1, 3);

    step("zero_c1", 4'b1000, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 4'b0000, 2, 1, 1, 1, 3);
    step("zero_c2", 4'b1000, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 4'b0000, 2, 1, 1, 1, 3);

    step("self_tgt", 4'b0100, 4'h0, 4'h0, 4'b0100, 4'h0, 4'b0100, 4'b0100, 2, 1, 2, 1, 3);

    step("pre_rst", 4'b0001, 4'b1111, 4'h0, 4'h0, 4'h0, 4'b0001, 4'b1111, 0, 0, 0, 0, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.req = 4'b0000;
    #1;
    compare("async_reset", observed(), 18'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst0", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    step("post_rst1", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
